// File: rtl/conv_pkg.sv
// Shared state encoding and sizing helpers for the streaming convolver control path.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } conv_state_t;

   localparam int unsigned KERN_DIM_DEF = 32'd3;
   localparam int unsigned IMG_W_DEF    = 32'd28;
   localparam int unsigned IMG_H_DEF    = 32'd28;
   localparam int unsigned WCOUNT_DEF   = KERN_DIM_DEF * KERN_DIM_DEF;

   function automatic int unsigned weight_count(input int unsigned k);
      return k * k;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/conv_valid_pipe.sv
// Valid-token shift register that tracks results through the MAC datapath.
module conv_valid_pipe #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic din,
   output logic dout,
   output logic empty
);

   logic [DEPTH-1:0] bits;

   // Shift one stage per enabled cycle; contents hold while the datapath stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bits <= {DEPTH{1'b0}};
      end else if (en) begin
         bits[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            bits[i] <= bits[i-1];
         end
      end
   end

   assign dout  = bits[DEPTH-1];
   assign empty = (bits == {DEPTH{1'b0}});

endmodule

// File: rtl/conv_ctrl_stream.sv
// Control path of the streaming convolver: weight load, pixel walk, window tracking.
// Define CONV_STRIDE_EN to honour the STRIDE parameter; otherwise stride is fixed at 1.
module conv_ctrl_stream
   import conv_pkg::*;
#(
   parameter int KERN_DIM = 3,
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int STRIDE   = 1,
   parameter int MAC_LAT  = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  reload_w,
   input  logic                                  w_valid,
   output logic                                  w_ready,
   output logic                                  weight_wr,
   output logic [$clog2(KERN_DIM*KERN_DIM)-1:0]  weight_addr,
   input  logic                                  pix_valid,
   output logic                                  pix_ready,
   output logic                                  shift_en,
   output logic                                  pipe_en,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  busy,
   output logic                                  done
);

   localparam int WAW = $clog2(weight_count(KERN_DIM));
   localparam int CW  = cnt_width(IMG_W);
   localparam int RW  = cnt_width(IMG_H);

   localparam logic [WAW-1:0] W_LAST   = WAW'(weight_count(KERN_DIM) - 32'd1);
   localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0]  COL_K1   = CW'(KERN_DIM - 1);
   localparam logic [RW-1:0]  ROW_K1   = RW'(KERN_DIM - 1);

   conv_state_t    state;
   conv_state_t    state_next;
   logic           weights_loaded;
   logic [WAW-1:0] waddr;
   logic [CW-1:0]  col;
   logic [CW-1:0]  col_next;
   logic [RW-1:0]  row;
   logic [RW-1:0]  row_next;
   logic           frame_start;
   logic           last_pix;
   logic           phase_ok;
   logic           win_valid;
   logic           pipe_out;
   logic           pipe_empty;

   assign pipe_en     = !(pipe_out && !out_ready);
   assign out_valid   = pipe_out;
   assign w_ready     = (state == LOAD_W);
   assign weight_wr   = w_valid && w_ready;
   assign weight_addr = waddr;
   assign pix_ready   = (state == RUN) && pipe_en;
   assign shift_en    = pix_valid && pix_ready;
   assign busy        = (state != IDLE);
   assign last_pix    = (col == COL_LAST) && (row == ROW_LAST);
   assign win_valid   = (row >= ROW_K1) && (col >= COL_K1) && phase_ok;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode, frame start and completion pulse.
   always_comb begin
      state_next  = state;
      frame_start = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               frame_start = 1'b1;
               state_next  = (reload_w || !weights_loaded) ? LOAD_W : RUN;
            end else begin
               state_next = IDLE;
            end
         end
         LOAD_W: begin
            if (weight_wr && (waddr == W_LAST)) begin
               state_next = RUN;
            end else begin
               state_next = LOAD_W;
            end
         end
         RUN: begin
            if (shift_en && last_pix) begin
               state_next = DRAIN;
            end else begin
               state_next = RUN;
            end
         end
         DRAIN: begin
            // pipe_empty covers the output stage, so a pending result blocks completion.
            if (pipe_empty) begin
               done       = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = DRAIN;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Weight index and the loaded-set flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         waddr          <= {WAW{1'b0}};
         weights_loaded <= 1'b0;
      end else if (frame_start) begin
         waddr <= {WAW{1'b0}};
      end else if (weight_wr) begin
         if (waddr == W_LAST) begin
            waddr          <= {WAW{1'b0}};
            weights_loaded <= 1'b1;
         end else begin
            waddr <= waddr + 1'b1;
         end
      end
   end

   // Raster position following the accepted pixel.
   always_comb begin
      col_next = col;
      row_next = row;
      if (col == COL_LAST) begin
         col_next = {CW{1'b0}};
         row_next = (row == ROW_LAST) ? {RW{1'b0}} : row + 1'b1;
      end else begin
         col_next = col + 1'b1;
      end
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col <= {CW{1'b0}};
         row <= {RW{1'b0}};
      end else if (frame_start) begin
         col <= {CW{1'b0}};
         row <= {RW{1'b0}};
      end else if (shift_en) begin
         col <= col_next;
         row <= row_next;
      end
   end

`ifdef CONV_STRIDE_EN
   localparam int PW = cnt_width(STRIDE);
   localparam logic [PW-1:0] PH_LAST = PW'(STRIDE - 1);

   logic [PW-1:0] ph_col;
   logic [PW-1:0] ph_row;

   // Phases restart at the first full-window position and then count modulo STRIDE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ph_col <= {PW{1'b0}};
         ph_row <= {PW{1'b0}};
      end else if (frame_start) begin
         ph_col <= {PW{1'b0}};
         ph_row <= {PW{1'b0}};
      end else if (shift_en) begin
         if ((col_next == COL_K1) || (ph_col == PH_LAST)) begin
            ph_col <= {PW{1'b0}};
         end else begin
            ph_col <= ph_col + 1'b1;
         end
         if (col == COL_LAST) begin
            if ((row_next == ROW_K1) || (ph_row == PH_LAST)) begin
               ph_row <= {PW{1'b0}};
            end else begin
               ph_row <= ph_row + 1'b1;
            end
         end
      end
   end

   assign phase_ok = (ph_col == {PW{1'b0}}) && (ph_row == {PW{1'b0}});
`else
   // Stride is fixed at 1 in this build, so every full window is emitted.
   localparam int STRIDE_EFF = (STRIDE > 0) ? 1 : 1;
   assign phase_ok = (STRIDE_EFF == 1);
`endif

   conv_valid_pipe #(
      .DEPTH (MAC_LAT)
   ) u_valid_pipe (
      .clk   (clk),
      .reset (reset),
      .en    (pipe_en),
      .din   (shift_en && win_valid),
      .dout  (pipe_out),
      .empty (pipe_empty)
   );

endmodule

// File: tb/tb_conv_ctrl_stream.sv
// Randomised self-checking bench for conv_ctrl_stream against a frame-level model.
module tb_conv_ctrl_stream;

   localparam int K   = 3;
   localparam int W   = 28;
   localparam int H   = 28;
   localparam int LAT = 4;
   localparam int KK  = K * K;
   localparam int WA  = $clog2(KK);
`ifdef CONV_STRIDE_EN
   localparam int S = 2;
`else
   localparam int S = 1;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          reload_w = 1'b0;
   logic          w_valid = 1'b0;
   logic          pix_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic          w_ready, weight_wr, pix_ready, shift_en, pipe_en, out_valid, busy, done;
   logic [WA-1:0] weight_addr;

   int n_vec = 0;
   int n_err = 0;

   conv_ctrl_stream #(
      .KERN_DIM (K), .IMG_W (W), .IMG_H (H), .STRIDE (2), .MAC_LAT (LAT)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .reload_w (reload_w),
      .w_valid (w_valid), .w_ready (w_ready), .weight_wr (weight_wr), .weight_addr (weight_addr),
      .pix_valid (pix_valid), .pix_ready (pix_ready), .shift_en (shift_en), .pipe_en (pipe_en),
      .out_valid (out_valid), .out_ready (out_ready), .busy (busy), .done (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_window(input int p);
      int r, c;
      r = p / W;
      c = p % W;
      return (r >= K - 1) && (c >= K - 1) && ((r - (K - 1)) % S == 0) && ((c - (K - 1)) % S == 0);
   endfunction

   function automatic int n_outputs();
      return ((W - K) / S + 1) * ((H - K) / S + 1);
   endfunction

   task automatic chk_reset_values();
      chk("rst_busy", busy, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_weight_wr", weight_wr, 0);
      chk("rst_weight_addr", weight_addr, 0);
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_shift_en", shift_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_pipe_en", pipe_en, 1);
   endtask

   // One frame from the start pulse; entered and left just after a rising edge.
   task automatic do_frame(input bit reload, input bit exp_load, input bit stall, input int abort_at);
      int  wcnt, pidx, nout, tokens, last_hs, last_acc, acc_first, first_ov, hold_left, stalled;
      bit  loading, running, draining, prev_stall, held, got_done, stall_now, exp_done, exp_ov;
      int  q[$];
      start = 1'b1; reload_w = reload; w_valid = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("start_idle_busy", busy, 0);
      @(posedge clk); #1;
      start = 1'b0;
      loading = exp_load; running = !exp_load; draining = 1'b0;
      wcnt = 0; pidx = 0; nout = 0; tokens = 0; last_hs = -1; last_acc = -1;
      acc_first = -1; first_ov = -1; hold_left = 0; stalled = 0;
      prev_stall = 1'b0; held = 1'b0; got_done = 1'b0;
      for (int t = 0; t < 6000 && !got_done; t++) begin
         reload_w = 1'($urandom_range(0, 1));
         start    = ((t % 97) == 13);
         w_valid  = ($urandom_range(0, 3) != 0);
         if (stall && !held && running && pidx >= 300) begin
            held = 1'b1;
            hold_left = 10;
         end
         pix_valid = (stall && !held && pidx >= 290) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (hold_left > 0) out_ready = 1'b0;
         else out_ready = stall ? ($urandom_range(0, 4) != 0) : 1'b1;
         @(negedge clk);
         stall_now = out_valid && !out_ready;
         chk("busy", busy, 1);
         chk("w_ready", w_ready, loading);
         chk("weight_wr", weight_wr, w_valid && loading);
         if (loading && w_valid) chk("weight_addr", weight_addr, wcnt);
         chk("pipe_en", pipe_en, !stall_now);
         chk("pix_ready", pix_ready, running && !stall_now);
         chk("shift_en", shift_en, pix_valid && running && !stall_now);
         if (!stall) begin
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = (q[0] + LAT == t);
            chk("out_valid_time", out_valid, exp_ov);
         end else begin
            if (prev_stall) chk("out_valid_hold", out_valid, 1);
            chk("out_valid_no_token", out_valid && (tokens == 0), 0);
         end
         if (hold_left > 0) begin
            if (out_valid) stalled++;
            hold_left--;
            if (hold_left == 0) chk("hold_stalls", stalled, 10);
         end
         exp_done = draining && (nout == n_outputs()) &&
                    (t == ((last_hs > last_acc) ? last_hs : last_acc) + 1);
         chk("done", done, exp_done);
         got_done = done;
         if (out_valid && first_ov < 0) first_ov = t;
         if (out_valid && out_ready) begin
            nout++;
            tokens--;
            last_hs = t;
            if (q.size() > 0) void'(q.pop_front());
         end
         if (running && pix_valid && !stall_now) begin
            if (is_window(pidx)) begin
               tokens++;
               q.push_back(t);
            end
            if (pidx == (K - 1) * W + (K - 1)) acc_first = t;
            last_acc = t;
            pidx++;
            if (pidx == W * H) begin
               running  = 1'b0;
               draining = 1'b1;
            end
         end
         if (loading && w_valid) begin
            wcnt++;
            if (wcnt == KK) begin
               loading = 1'b0;
               running = 1'b1;
            end
         end
         prev_stall = stall_now;
         if (abort_at > 0 && t == abort_at) return;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("frame_completed", got_done, 1);
      chk("n_outputs", nout, n_outputs());
      if (!stall) chk("first_out_latency", first_ov - acc_first, LAT);
      @(negedge clk);
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_values();
      reset = 1'b1;
      @(posedge clk); #1;

      do_frame(1'b1, 1'b1, 1'b0, 0);   // fresh weights, free-running output
      do_frame(1'b0, 1'b0, 1'b0, 0);   // reuse weights: straight to RUN
      do_frame(1'b0, 1'b0, 1'b1, 0);   // backpressure, including a 10-cycle hold
      do_frame(1'b0, 1'b0, 1'b0, 300); // abandoned mid-RUN by reset

      reset = 1'b0;
      #1;
      chk_reset_values();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_hold_done", done, 0);
         chk("reset_hold_busy", busy, 0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      pix_valid = 1'b0;
      w_valid = 1'b0;
      @(posedge clk); #1;

      do_frame(1'b0, 1'b1, 1'b0, 0);   // weights were lost: reload forced
      do_frame(1'b0, 1'b0, 1'b1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
